ha: RTL and testbench
=====================

Name: ha

Overview:
- Bitwise half-adder bank with two output sets: combinational sum/carry, and a registered copy with a valid flag.
- Also keeps a saturating count of carry-generating transfers.
- Leaf arithmetic cell used by ripple/carry-save adder structures and by bring-up benches that drive only A/B and read S/Cout.

Parameters:
- WIDTH, 1, number of independent half-adder lanes.
- CNT_W, 8, width of carry event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- A  in  WIDTH  addend operand, lane i = bit i.
- B  in  WIDTH  augend operand.
- in_valid  in  1  A/B qualify for registered path.
- S  out  WIDTH  combinational sum, A XOR B.
- Cout  out  WIDTH  combinational carry, A AND B.
- S_q  out  WIDTH  registered sum.
- Cout_q  out  WIDTH  registered carry.
- out_valid  out  1  S_q/Cout_q hold a captured result.
- carry_cnt  out  CNT_W  saturating count of captured transfers with any Cout bit set.

Behaviour:
- S[i] = A[i] ^ B[i]; Cout[i] = A[i] & B[i]; per lane, no inter-lane carry.
- S/Cout are purely combinational, zero latency.
- S/Cout are independent of clk and rst: valid with clock idle and during reset.
- On every rising clk edge with rst=1:
  - S_q=0, Cout_q=0, out_valid=0, carry_cnt=0.
  - Reset has priority over in_valid.
- Rising edge, rst=0, in_valid=1:
  - S_q<=S, Cout_q<=Cout, out_valid<=1 (1-cycle latency).
  - If |Cout, carry_cnt<=carry_cnt+1, saturating at all-ones (no wrap).
- Rising edge, rst=0, in_valid=0: S_q/Cout_q hold, out_valid<=0, carry_cnt holds.
- Back-to-back in_valid: every cycle captured; no backpressure, no stall.
- Reset mid-stream clears the registered path on that edge; next capture needs in_valid in a later cycle.
- X on A/B propagates to S/Cout; no X masking.

Decomposition:
- Shared package ha_pkg: default WIDTH/CNT_W constants; function computing {Cout,S} for one bit (reused by full-adder blocks).
- Sub-module ha_bit: 1-bit combinational cell (a, b -> s, c), generated WIDTH times.
- Registers and counter live in ha.

Test Plan:
- Comb truth table, WIDTH=1, clk idle, rst=1, 20 ns per step:
  - A=0,B=0 -> S=0,Cout=0.
  - A=0,B=1 -> S=1,Cout=0.
  - A=1,B=0 -> S=1,Cout=0.
  - A=1,B=1 -> S=0,Cout=1.
  - All settle within the step; no clock needed.
- Reset: hold rst=1 two edges with A=B=1,in_valid=1 -> S_q=0,Cout_q=0,out_valid=0,carry_cnt=0; S=0,Cout=1 throughout.
- Registered latency, WIDTH=4: A=4'b1100,B=4'b1010,in_valid=1 one cycle -> S=0110,Cout=1000 immediately. Next edge S_q=0110,Cout_q=1000,out_valid=1,carry_cnt=1. Following edge, in_valid=0 -> out_valid=0, S_q/Cout_q unchanged.
- Carry counting: 3 valid cycles A=B=0001, then 2 with A=0001,B=0 -> carry_cnt=3.
- Saturation, CNT_W=2: 5 consecutive valid carry cycles -> carry_cnt 1,2,3,3,3.
- Reset mid-stream: streaming valid data with A=B=1, rst=1 for one edge -> all registered outputs 0 that edge. Following valid cycle -> carry_cnt=1.

Source files
------------

// File: rtl/ha_pkg.sv
// Shared definitions for the half-adder bank: default sizes and the one-bit
// half-add function that full-adder blocks also build on.
package ha_pkg;

    localparam int HA_WIDTH = 1;
    localparam int HA_CNT_W = 8;

    typedef struct packed {
        logic c;
        logic s;
    } ha_res_t;

    function automatic ha_res_t ha_add(input logic a, input logic b);
        ha_res_t r;
        r.s = a ^ b;
        r.c = a & b;
        return r;
    endfunction

endpackage

// File: rtl/ha_bit.sv
// One-bit combinational half-adder cell; no clock, no state.
module ha_bit
    import ha_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    ha_res_t res;

    assign res = ha_add(a, b);
    assign s   = res.s;
    assign c   = res.c;

endmodule

// File: rtl/ha.sv
// Bank of independent half-adder lanes with a zero-latency output, a registered
// copy qualified by out_valid, and a saturating count of captured carries.
module ha
    import ha_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH,
    parameter int CNT_W = HA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Cout,
    output logic [WIDTH-1:0] S_q,
    output logic [WIDTH-1:0] Cout_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_bit u_bit (
            .a (A[i]),
            .b (B[i]),
            .s (S[i]),
            .c (Cout[i])
        );
    end

    logic [WIDTH-1:0] sum_q,   sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = in_valid;
        cnt_d   = cnt_q;
        if (in_valid) begin
            sum_d   = S;
            carry_d = Cout;
            if ((|Cout) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S_q       = sum_q;
    assign Cout_q    = carry_q;
    assign out_valid = valid_q;
    assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_ha.sv
// Directed bench for ha: a 4-lane/8-bit-counter instance and a 1-lane/2-bit-counter
// instance, registered results checked through per-instance scoreboards.
module tb_ha;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst;

    logic [3:0] a_a, b_a, s_a, c_a, sq_a, cq_a;
    logic       v_a, ov_a;
    logic [7:0] cnt_a;

    logic       a_s, b_s, s_s, c_s, sq_s, cq_s;
    logic       v_s, ov_s;
    logic [1:0] cnt_s;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] s;
        logic [3:0] c;
        logic [7:0] cnt;
    } exp_a_t;

    typedef struct {
        logic       s;
        logic       c;
        logic [1:0] cnt;
    } exp_s_t;

    exp_a_t q_a[$];
    exp_s_t q_s[$];

    always #5 if (clk_en) clk = ~clk;

    ha #(.WIDTH(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .A(a_a), .B(b_a), .in_valid(v_a),
        .S(s_a), .Cout(c_a), .S_q(sq_a), .Cout_q(cq_a),
        .out_valid(ov_a), .carry_cnt(cnt_a)
    );

    ha #(.WIDTH(1), .CNT_W(2)) u_dut_s (
        .clk(clk), .rst(rst), .A(a_s), .B(b_s), .in_valid(v_s),
        .S(s_s), .Cout(c_s), .S_q(sq_s), .Cout_q(cq_s),
        .out_valid(ov_s), .carry_cnt(cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors pop one expected entry per cycle in which a DUT presents out_valid.
    always @(negedge clk) begin
        if (ov_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_valid", 32'(q_a.size()), 32'd1);
            end else begin
                exp_a_t e;
                e = q_a.pop_front();
                check("a_S_q", 32'(sq_a), 32'(e.s));
                check("a_Cout_q", 32'(cq_a), 32'(e.c));
                check("a_carry_cnt", 32'(cnt_a), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (ov_s === 1'b1) begin
            if (q_s.size() == 0) begin
                check("s_unexpected_valid", 32'(q_s.size()), 32'd1);
            end else begin
                exp_s_t e;
                e = q_s.pop_front();
                check("s_S_q", 32'(sq_s), 32'(e.s));
                check("s_Cout_q", 32'(cq_s), 32'(e.c));
                check("s_carry_cnt", 32'(cnt_s), 32'(e.cnt));
            end
        end
    end

    task automatic drive_a(input logic [3:0] a, input logic [3:0] b, input logic v,
                           input logic [3:0] es, input logic [3:0] ec, input logic [7:0] ecnt);
        exp_a_t e;
        a_a = a;
        b_a = b;
        v_a = v;
        if (v) begin
            e.s = es; e.c = ec; e.cnt = ecnt;
            q_a.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drive_s(input logic a, input logic b, input logic v,
                           input logic es, input logic ec, input logic [1:0] ecnt);
        exp_s_t e;
        a_s = a;
        b_s = b;
        v_s = v;
        if (v) begin
            e.s = es; e.c = ec; e.cnt = ecnt;
            q_s.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] tt [4];
        logic [1:0] sat [5];
        tt[0] = 4'b00_00; tt[1] = 4'b01_10; tt[2] = 4'b10_10; tt[3] = 4'b11_01; // {a,b,s,c}
        sat[0] = 2'd1; sat[1] = 2'd2; sat[2] = 2'd3; sat[3] = 2'd3; sat[4] = 2'd3;

        rst = 1'b1;
        a_a = '0; b_a = '0; v_a = 1'b0;
        a_s = 1'b0; b_s = 1'b0; v_s = 1'b0;

        // Combinational truth table with the clock idle and reset asserted.
        for (int i = 0; i < 4; i++) begin
            a_s = tt[i][3];
            b_s = tt[i][2];
            #20;
            check("tt_S", 32'(s_s), 32'(tt[i][1]));
            check("tt_Cout", 32'(c_s), 32'(tt[i][0]));
        end

        // Reset holds registers at zero even with valid carry data presented.
        a_s = 1'b1; b_s = 1'b1; v_s = 1'b1;
        a_a = 4'hF; b_a = 4'hF; v_a = 1'b1;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_a_S_q", 32'(sq_a), 32'd0);
        check("rst_a_Cout_q", 32'(cq_a), 32'd0);
        check("rst_a_out_valid", 32'(ov_a), 32'd0);
        check("rst_a_carry_cnt", 32'(cnt_a), 32'd0);
        check("rst_s_out_valid", 32'(ov_s), 32'd0);
        check("rst_s_carry_cnt", 32'(cnt_s), 32'd0);
        check("rst_s_S", 32'(s_s), 32'd0);
        check("rst_s_Cout", 32'(c_s), 32'd1);
        v_a = 1'b0; v_s = 1'b0;
        rst = 1'b0;

        // One-cycle latency, then hold with in_valid low.
        a_a = 4'b1100; b_a = 4'b1010; v_a = 1'b1;
        #1;
        check("lat_S", 32'(s_a), 32'b0110);
        check("lat_Cout", 32'(c_a), 32'b1000);
        drive_a(4'b1100, 4'b1010, 1'b1, 4'b0110, 4'b1000, 8'd1);
        drive_a(4'b0011, 4'b0011, 1'b0, 4'b0, 4'b0, 8'd0);
        check("hold_out_valid", 32'(ov_a), 32'd0);
        check("hold_S_q", 32'(sq_a), 32'b0110);
        check("hold_Cout_q", 32'(cq_a), 32'b1000);
        check("hold_carry_cnt", 32'(cnt_a), 32'd1);

        // Carry counting from a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive_a(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 8'd1);
        drive_a(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 8'd2);
        drive_a(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 8'd3);
        drive_a(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 8'd3);
        drive_a(4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 8'd3);
        drive_a(4'b0000, 4'b0000, 1'b0, 4'b0, 4'b0, 8'd0);
        check("cnt_final", 32'(cnt_a), 32'd3);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            drive_s(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, sat[i]);
        end
        drive_s(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("sat_final", 32'(cnt_s), 32'd3);

        // Reset in the middle of a valid stream wins over in_valid.
        drive_a(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 8'd4);
        drive_a(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 8'd5);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("mid_S_q", 32'(sq_a), 32'd0);
        check("mid_Cout_q", 32'(cq_a), 32'd0);
        check("mid_out_valid", 32'(ov_a), 32'd0);
        check("mid_carry_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        drive_a(4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 8'd1);
        drive_a(4'b0000, 4'b0000, 1'b0, 4'b0, 4'b0, 8'd0);

        @(negedge clk);
        check("q_a_drained", 32'(q_a.size()), 32'd0);
        check("q_s_drained", 32'(q_s.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
